// File: rtl/fft_pkg.sv
// Shared FFT constants, the frame sequencer state encoding and the 5-bit
// bit-reverse helper that the frame buffer also uses.
`timescale 1ns/1ps
package fft_pkg;

  localparam int FFT_POINTS = 32;
  localparam int FFT_LOG2   = 5;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_WAIT   = 3'd3,
    S_UNLOAD = 3'd4
  } state_e;

  function automatic logic [FFT_LOG2-1:0] bitrev5(input logic [FFT_LOG2-1:0] a);
    logic [FFT_LOG2-1:0] r;
    for (int i = 0; i < FFT_LOG2; i++) r[i] = a[FFT_LOG2-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft32_stage_sequencer_if.sv
// Control bundle between the FFT frame sequencer (master) and the sample
// source / stage datapath / frame buffer / result sink (slave).
`timescale 1ns/1ps
interface fft32_stage_sequencer_if;
  import fft_pkg::*;

  logic                i_in_valid;
  logic                o_in_ready;
  logic                o_buf_we;
  logic [FFT_LOG2-1:0] o_buf_addr;
  logic                o_stage_start;
  logic [2:0]          o_stage_sel;
  logic                o_src_bank;
  logic                o_wb_en;
  logic                o_out_valid;
  logic                i_out_ready;
  logic [FFT_LOG2-1:0] o_out_addr;
  logic                o_out_last;
  logic                o_rd_bank;
  logic                o_busy;
  logic                o_frame_done;

  modport master (
    input  i_in_valid, i_out_ready,
    output o_in_ready, o_buf_we, o_buf_addr, o_stage_start, o_stage_sel,
           o_src_bank, o_wb_en, o_out_valid, o_out_addr, o_out_last,
           o_rd_bank, o_busy, o_frame_done
  );

  modport slave (
    output i_in_valid, i_out_ready,
    input  o_in_ready, o_buf_we, o_buf_addr, o_stage_start, o_stage_sel,
           o_src_bank, o_wb_en, o_out_valid, o_out_addr, o_out_last,
           o_rd_bank, o_busy, o_frame_done
  );
endinterface

// File: rtl/fft32_stage_sequencer.sv
// Frame-level controller for the 32-point FFT: load, five stage passes, unload.
// Define FFT_SEQ_BITREV_EN to emit results in natural frequency order.
`timescale 1ns/1ps
module fft32_stage_sequencer
  import fft_pkg::*;
#(
  parameter int P_STAGES        = 5,
  parameter int P_STAGE_LATENCY = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  fft32_stage_sequencer_if.master bus
);

  localparam logic [2:0]          LAT_LAST   = 3'(P_STAGE_LATENCY - 1);
  localparam logic [2:0]          STAGE_LAST = 3'(P_STAGES - 1);
  localparam logic [FFT_LOG2-1:0] CNT_LAST   = '1;

  state_e              state_q, state_d;
  logic [FFT_LOG2-1:0] smp_cnt_q, smp_cnt_d;
  logic [2:0]          stage_q, stage_d;
  logic [2:0]          lat_cnt_q, lat_cnt_d;
  logic [FFT_LOG2-1:0] out_cnt_q, out_cnt_d;
  logic                frame_done_q, frame_done_d;
  logic                in_ready;
  logic                accept;

  assign in_ready = (state_q == S_IDLE) || (state_q == S_LOAD);
  assign accept   = bus.i_in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    smp_cnt_d    = smp_cnt_q;
    stage_d      = stage_q;
    lat_cnt_d    = lat_cnt_q;
    out_cnt_d    = out_cnt_q;
    frame_done_d = 1'b0;
    case (state_q)
      S_IDLE, S_LOAD: begin
        if (accept) begin
          // The 32nd accept wraps the sample counter back to 0 for the next frame.
          smp_cnt_d = smp_cnt_q + 5'd1;
          if (smp_cnt_q == CNT_LAST) begin
            state_d = S_RUN;
            stage_d = '0;
          end else begin
            state_d = S_LOAD;
          end
        end
      end
      S_RUN: begin
        state_d   = S_WAIT;
        lat_cnt_d = '0;
      end
      S_WAIT: begin
        if (lat_cnt_q == LAT_LAST) begin
          if (stage_q == STAGE_LAST) begin
            state_d = S_UNLOAD;
          end else begin
            stage_d = stage_q + 3'd1;
            state_d = S_RUN;
          end
        end else begin
          lat_cnt_d = lat_cnt_q + 3'd1;
        end
      end
      S_UNLOAD: begin
        if (bus.i_out_ready) begin
          out_cnt_d = out_cnt_q + 5'd1;
          if (out_cnt_q == CNT_LAST) begin
            state_d      = S_IDLE;
            frame_done_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      smp_cnt_q    <= '0;
      stage_q      <= '0;
      lat_cnt_q    <= '0;
      out_cnt_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      smp_cnt_q    <= smp_cnt_d;
      stage_q      <= stage_d;
      lat_cnt_q    <= lat_cnt_d;
      out_cnt_q    <= out_cnt_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Everything below decodes registered state; only o_buf_we sees an input.
  assign bus.o_in_ready    = in_ready;
  assign bus.o_buf_we      = accept;
  assign bus.o_buf_addr    = smp_cnt_q;
  assign bus.o_stage_start = (state_q == S_RUN);
  assign bus.o_stage_sel   = stage_q;
  assign bus.o_src_bank    = stage_q[0];
  assign bus.o_wb_en       = (state_q == S_WAIT) && (lat_cnt_q == LAT_LAST);
  assign bus.o_out_valid   = (state_q == S_UNLOAD);
`ifdef FFT_SEQ_BITREV_EN
  assign bus.o_out_addr    = bitrev5(out_cnt_q);
`else
  assign bus.o_out_addr    = out_cnt_q;
`endif
  assign bus.o_out_last    = (state_q == S_UNLOAD) && (out_cnt_q == CNT_LAST);
  assign bus.o_rd_bank     = 1'(P_STAGES % 2);
  assign bus.o_busy        = (state_q != S_IDLE);
  assign bus.o_frame_done  = frame_done_q;

endmodule

// File: tb/tb_fft32_stage_sequencer.sv
// Directed bench for fft32_stage_sequencer: one L=1 and one L=3 instance share
// stimulus; a per-cycle vector table covers a full frame, hand sequences cover corners.
`timescale 1ns/1ps
module tb_fft32_stage_sequencer;
  import fft_pkg::*;

  typedef struct packed {
    logic       in_ready;
    logic       buf_we;
    logic [4:0] buf_addr;
    logic       stage_start;
    logic [2:0] stage_sel;
    logic       src_bank;
    logic       wb_en;
    logic       out_valid;
    logic [4:0] out_addr;
    logic       out_last;
    logic       rd_bank;
    logic       busy;
    logic       frame_done;
  } out_t;

  typedef struct packed {
    logic in_valid;
    logic out_ready;
    out_t exp;
  } vec_t;

  localparam int NVEC = 85;

  logic clk = 1'b0;
  logic rst;
  int   n_vec = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  fft32_stage_sequencer_if if1();
  fft32_stage_sequencer_if if3();

  fft32_stage_sequencer #(.P_STAGES(5), .P_STAGE_LATENCY(1)) dut1 (
    .CLK(clk), .RST(rst), .bus(if1)
  );
  fft32_stage_sequencer #(.P_STAGES(5), .P_STAGE_LATENCY(3)) dut3 (
    .CLK(clk), .RST(rst), .bus(if3)
  );

  function automatic logic [4:0] exp_addr(input int n);
    logic [4:0] v;
    v = 5'(n);
`ifdef FFT_SEQ_BITREV_EN
    return {v[0], v[1], v[2], v[3], v[4]};
`else
    return v;
`endif
  endfunction

  function automatic out_t sample1();
    out_t o;
    o.in_ready    = if1.o_in_ready;
    o.buf_we      = if1.o_buf_we;
    o.buf_addr    = if1.o_buf_addr;
    o.stage_start = if1.o_stage_start;
    o.stage_sel   = if1.o_stage_sel;
    o.src_bank    = if1.o_src_bank;
    o.wb_en       = if1.o_wb_en;
    o.out_valid   = if1.o_out_valid;
    o.out_addr    = if1.o_out_addr;
    o.out_last    = if1.o_out_last;
    o.rd_bank     = if1.o_rd_bank;
    o.busy        = if1.o_busy;
    o.frame_done  = if1.o_frame_done;
    return o;
  endfunction

  function automatic logic [7:0] sample3();
    return {if3.o_stage_start, if3.o_stage_sel, if3.o_wb_en, if3.o_out_valid,
            if3.o_out_last, if3.o_frame_done};
  endfunction

  // L=3 expectations, c counted from the edge of the 32nd accept.
  function automatic logic [7:0] exp3(input int c);
    logic       st, wb, vl, la, fd;
    logic [2:0] sel;
    st  = (c >= 1) && (c <= 17) && ((c - 1) % 4 == 0);
    wb  = (c >= 4) && (c <= 20) && (c % 4 == 0);
    vl  = (c >= 21) && (c <= 52);
    la  = (c == 52);
    fd  = (c == 53);
    sel = (c < 1) ? 3'd0 : (c <= 20) ? 3'((c - 1) / 4) : 3'd4;
    return {st, sel, wb, vl, la, fd};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic r);
    if1.i_in_valid  = v;
    if3.i_in_valid  = v;
    if1.i_out_ready = r;
    if3.i_out_ready = r;
  endtask

  // One cycle: inputs change just after the edge, outputs are read at negedge.
  task automatic cyc(input logic v, input logic r);
    @(posedge clk);
    #1;
    drive(v, r);
    @(negedge clk);
  endtask

  vec_t tbl [NVEC];
  out_t e;
  out_t rst_o;
  int   c;
  int   acc;
  int   guard;
  int   n;
  logic v;

  initial begin
    for (int i = 0; i < NVEC; i++) begin
      c = i - 31;
      e = '0;
      e.rd_bank = 1'b1;
      tbl[i].in_valid  = (c <= 0);
      tbl[i].out_ready = 1'b1;
      if (c <= 0) begin
        e.in_ready = 1'b1;
        e.buf_we   = 1'b1;
        e.buf_addr = 5'(i);
        e.busy     = (i != 0);
      end else if (c <= 10) begin
        e.busy        = 1'b1;
        e.stage_sel   = 3'((c - 1) / 2);
        e.src_bank    = 1'(((c - 1) / 2) % 2);
        e.stage_start = (c % 2 == 1);
        e.wb_en       = (c % 2 == 0);
      end else if (c <= 42) begin
        e.busy      = 1'b1;
        e.stage_sel = 3'd4;
        e.out_valid = 1'b1;
        e.out_addr  = exp_addr(c - 11);
        e.out_last  = (c == 42);
      end else begin
        e.in_ready   = 1'b1;
        e.stage_sel  = 3'd4;
        e.frame_done = (c == 43);
      end
      tbl[i].exp = e;
    end

    rst_o          = '0;
    rst_o.in_ready = 1'b1;
    rst_o.rd_bank  = 1'b1;

    rst = 1'b1;
    drive(1'b0, 1'b0);
    @(negedge clk);
    chk("reset held L1", sample1(), rst_o);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset idle L1", sample1(), rst_o);
    chk("reset idle L3", sample3(), 8'h00);

    for (int i = 0; i < NVEC; i++) begin
      cyc(tbl[i].in_valid, tbl[i].out_ready);
      chk($sformatf("frame L1 c=%0d", i - 31), sample1(), tbl[i].exp);
      chk($sformatf("frame L3 c=%0d", i - 31), sample3(), exp3(i - 31));
    end

    // Random gaps on i_in_valid during load: exactly 32 accepts, none while low.
    acc   = 0;
    guard = 0;
    while (acc < 32 && guard < 400) begin
      v = 1'($urandom_range(0, 1));
      guard++;
      cyc(v, 1'b1);
      if (v) begin
        chk("rnd load we/addr", {if1.o_buf_we, if1.o_buf_addr}, {1'b1, 5'(acc)});
        acc++;
      end else begin
        chk("rnd load no we", {31'd0, if1.o_buf_we}, 32'd0);
      end
    end
    chk("rnd accept count", acc, 32);

    for (int k = 1; k <= 10; k++) begin
      cyc(1'b1, 1'b0);
      chk($sformatf("run ignores input c=%0d", k),
          {if1.o_in_ready, if1.o_buf_we, if3.o_in_ready, if3.o_buf_we}, 32'd0);
    end
    repeat (5) cyc(1'b0, 1'b1);
    for (int k = 0; k < 10; k++) begin
      cyc(1'b0, 1'b0);
      chk($sformatf("backpressure hold %0d", k),
          {if1.o_out_valid, if1.o_out_addr, if1.o_out_last}, {1'b1, exp_addr(5), 1'b0});
    end

    n = 0;
    do begin
      cyc(1'b0, 1'b1);
      n++;
    end while (!if1.o_frame_done && n < 100);
    chk("frame_done after backpressure", n, 28);

    cyc(1'b1, 1'b1);
    chk("accept after done", {if1.o_in_ready, if1.o_buf_we, if1.o_buf_addr, if1.o_busy},
        {1'b1, 1'b1, 5'd0, 1'b0});
    cyc(1'b0, 1'b1);
    chk("busy after accept", {if1.o_busy, if1.o_buf_addr}, {1'b1, 5'd1});

    // Fill the rest of the frame, then abort with reset at output count 12.
    repeat (31) cyc(1'b1, 1'b1);
    repeat (10) cyc(1'b0, 1'b1);
    repeat (13) cyc(1'b0, 1'b1);
    chk("pre-reset unload addr", {if1.o_out_valid, if1.o_out_addr}, {1'b1, exp_addr(12)});
    #2 rst = 1'b1;
    #1;
    chk("async reset state", {29'd0, dut1.state_q}, {29'd0, S_IDLE});
    chk("async reset outputs", sample1(), rst_o);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post-reset idle", sample1(), rst_o);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fft32_stage_sequencer.md
# fft32_stage_sequencer

- Frame-level controller for the 32-point FFT datapath.
- Loads 32 serial real samples into a ping-pong frame buffer.
- Runs the shared radix-2 stage datapath five times, one pass per FFT stage, selecting stage twiddles and buffer banks for each pass, then streams the 32 results out under a valid/ready handshake.
- Sits between the sample source and the stage/frame-buffer datapath; drives only control, addresses and selects, never sample data.

## Interface
- P_STAGES, 5: FFT stages per frame (log2 of 32); fixed at 5.
- P_STAGE_LATENCY, 1: stage datapath cycles from start to registered result; legal range 1..7.
- CLK  in  1  clock; all logic is rising-edge.
- RST  in  1  reset; asynchronous, active-high.
- i_in_valid  in  1  input sample valid.
- o_in_ready  out  1  sequencer accepts a sample this cycle.
- o_buf_we  out  1  write the accepted sample into bank 0.
- o_buf_addr  out  5  load write address, equal to the sample index.
- o_stage_start  out  1  one-cycle pulse that launches a stage pass.
- o_stage_sel  out  3  current stage index 0..4; selects the stage twiddle set.
- o_src_bank  out  1  bank read by the stage pass.
- o_wb_en  out  1  capture stage results into bank ~o_src_bank.
- o_out_valid  out  1  output address is valid.
- i_out_ready  in  1  downstream consumer accepts the output.
- o_out_addr  out  5  result read address.
- o_out_last  out  1  o_out_valid is high for the 32nd output.
- o_rd_bank  out  1  bank read during unload; equals P_STAGES%2, so 1.
- o_busy  out  1  sequencer is in any state other than IDLE.
- o_frame_done  out  1  one-cycle pulse after the final output handshake.

## Operation
- States: IDLE, LOAD, RUN, WAIT, UNLOAD.
- Reset: state IDLE; all counters 0; o_src_bank 0; all outputs 0 except o_in_ready=1 and o_rd_bank=1.
- IDLE/LOAD: o_in_ready=1. Each accept (i_in_valid&o_in_ready) sets o_buf_we=1 and o_buf_addr=sample counter, combinationally.
  - The first accept moves the sequencer from IDLE to LOAD.
  - The accept at count 31 moves it to RUN and clears the counter; count wraps to 0.
- RUN: for one cycle, o_stage_start=1 and o_stage_sel=k, with k reset to 0 on entry from LOAD. o_src_bank=k%2. Next state is WAIT with the latency counter at 0.
- WAIT: lasts P_STAGE_LATENCY cycles. o_stage_sel and o_src_bank stay stable.
  - On the last WAIT cycle, o_wb_en=1.
  - Then, if k<4: k increments and the next state is RUN.
  - If k=4: the next state is UNLOAD.
- UNLOAD: o_out_valid=1. The output counter advances only on i_out_ready.
  - o_out_last=1 when the counter is 31.
  - The handshake with o_out_last high moves the sequencer to IDLE, sets o_frame_done=1 for one cycle and clears the counter.
- Outside IDLE/LOAD, o_in_ready=0 and i_in_valid is ignored. No sample is lost, because the source holds the sample.
- Back-pressure: if i_out_ready is held low, o_out_valid, o_out_addr and o_out_last hold indefinitely.
- Any RST assertion mid-frame aborts to the reset values on the same edge. The partial frame is discarded.
- A new frame may be accepted in the cycle right after o_frame_done. IDLE accepts on its first cycle.

## Timing
- With the 32nd accept on edge E0, o_stage_start is high in cycle 1, and the cycle k*(1+L)+1 carries the start for stage k, where L=P_STAGE_LATENCY.
- o_wb_en for stage k is high in cycle (k+1)*(1+L).
- UNLOAD, with o_out_valid high, begins in cycle 5*(1+L)+1; with the default L=1 this is cycle 11.
- Minimum frame period: 32 load + 5*(1+L) compute + 32 unload cycles. With L=1 this is 74 cycles.
- All outputs are registered or decoded from the registered state and counters. The only combinational input-to-output paths are o_buf_we (from i_in_valid) and the output counter advance (from i_out_ready).

## Configuration
- FFT_SEQ_BITREV_EN defined: o_out_addr = bit-reverse(output counter), giving results in natural frequency order.
- Not defined: o_out_addr = output counter.
- o_out_last always tracks the counter (count 31), not the address.

## Structure
- fft_pkg holds:
  - FFT_POINTS=32 and FFT_LOG2=5.
  - The state enum typedef (IDLE, LOAD, RUN, WAIT, UNLOAD).
  - A bitrev5 function, also used by the frame buffer.
- No sub-module is needed. Counters and the FSM live in a single module.

## Test plan
- Reset mid-UNLOAD at counter 12: on the edge, state is IDLE, o_out_valid=0, o_in_ready=1, o_busy=0 and o_rd_bank=1.
- 32 back-to-back samples, L=1, i_out_ready=1:
  - o_buf_addr runs 0..31.
  - o_stage_start appears in cycles 1, 3, 5, 7, 9 with o_stage_sel 0..4 and o_src_bank 0, 1, 0, 1, 0.
  - o_out_valid is first high in cycle 11.
  - o_frame_done is high in cycle 43.
- L=3: starts in cycles 1, 5, 9, 13, 17; o_wb_en in cycles 4, 8, 12, 16, 20; UNLOAD begins in cycle 21.
- i_in_valid toggled randomly during load: exactly 32 accepts, with no o_buf_we while i_in_valid=0; i_in_valid during RUN/WAIT gives o_in_ready=0 and no writes.
- i_out_ready low for 10 cycles at count 5: o_out_addr stays at 5 (at 20 with FFT_SEQ_BITREV_EN) and o_out_valid stays high throughout.
- The sample after o_frame_done is accepted immediately, with o_buf_addr 0 and o_busy=1 on the next cycle.
